// File: rtl/oq_axi_regs.sv
// oq_axi_regs: AXI4-Lite control/status registers for the
// BRAM output-queue subsystem with NUM_QUEUES channels.
module oq_axi_regs #(
  parameter int NUM_QUEUES = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             ACLK,
  input  logic                             ARESETN,
  input  logic [ADDR_WIDTH-1:0]            AWADDR,
  input  logic                             AWVALID,
  output logic                             AWREADY,
  input  logic [DATA_WIDTH-1:0]            WDATA,
  input  logic [DATA_WIDTH/8-1:0]          WSTRB,
  input  logic                             WVALID,
  output logic                             WREADY,
  output logic [1:0]                       BRESP,
  output logic                             BVALID,
  input  logic                             BREADY,
  input  logic [ADDR_WIDTH-1:0]            ARADDR,
  input  logic                             ARVALID,
  output logic                             ARREADY,
  output logic [DATA_WIDTH-1:0]            RDATA,
  output logic [1:0]                       RRESP,
  output logic                             RVALID,
  input  logic                             RREADY,
  output logic [DATA_WIDTH-1:0]            queues_num,
  output logic                             reset_drop_counts,
  output logic [DATA_WIDTH*NUM_QUEUES-1:0] split_ratio,
  input  logic [DATA_WIDTH*NUM_QUEUES-1:0] drop_count
);
  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [4:0] NQ5 = 5'(NUM_QUEUES);
  localparam logic [DW-1:0] NQW = DW'(NUM_QUEUES);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_RESP} rstate_e;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old,
    input logic [DW-1:0] nw,
    input logic [SW-1:0] strb
  );
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++)
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  wstate_e         w_state_q, w_state_d;
  rstate_e         r_state_q, r_state_d;
  logic            aw_held_q, aw_held_d;
  logic            w_held_q, w_held_d;
  logic [7:0]      awidx_q, awidx_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [1:0]      bresp_q, rresp_q;
  logic [DW-1:0]   rdata_q, qnum_q;
  logic            rdc_q;
  logic [DW-1:0]   split_q [NUM_QUEUES];

  logic            aw_fire, w_fire, ar_fire, apply;
  logic [7:0]      wr_idx, r_idx;
  logic [DW-1:0]   wr_data, qnum_mrg, qnum_sat;
  logic [SW-1:0]   wr_strb;
  logic            wr_qn, wr_ctl, wr_sr, wr_ok;
  logic            rd_dc, rd_sr;
  logic [DW-1:0]   dc_sel, sr_sel, rd_data;
  logic [1:0]      rd_resp;
  logic            unused_addr;

  assign unused_addr = ^{AWADDR[ADDR_WIDTH-1:10], AWADDR[1:0],
                         ARADDR[ADDR_WIDTH-1:10], ARADDR[1:0]};

  assign AWREADY = ARESETN && (w_state_q == W_IDLE) && !aw_held_q;
  assign WREADY  = ARESETN && (w_state_q == W_IDLE) && !w_held_q;
  assign BVALID  = (w_state_q == W_RESP);
  assign BRESP   = bresp_q;
  assign ARREADY = ARESETN && (r_state_q == R_IDLE);
  assign RVALID  = (r_state_q == R_RESP);
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign queues_num = qnum_q;
  assign reset_drop_counts = rdc_q;

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_sr
    assign split_ratio[DW*g +: DW] = split_q[g];
  end

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign ar_fire = ARVALID && ARREADY;

  // A held beat wins; otherwise the beat being accepted this cycle.
  assign wr_idx  = aw_held_q ? awidx_q : AWADDR[9:2];
  assign wr_data = w_held_q ? wdata_q : WDATA;
  assign wr_strb = w_held_q ? wstrb_q : WSTRB;

  assign wr_qn  = (wr_idx == 8'h00);
  assign wr_ctl = (wr_idx == 8'h01);
  assign wr_sr  = (wr_idx[7:4] == 4'h2) && ({1'b0, wr_idx[3:0]} < NQ5);
  assign wr_ok  = wr_qn || wr_ctl || wr_sr;

  assign qnum_mrg = merge(qnum_q, wr_data, wr_strb);
  assign qnum_sat = (qnum_mrg > NQW) ? NQW : qnum_mrg;

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    apply     = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awidx_d   = AWADDR[9:2];
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
        end
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          apply     = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE: if (ar_fire) r_state_d = R_RESP;
      R_RESP: if (RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      bresp_q <= OKAY;
      qnum_q  <= '0;
      rdc_q   <= 1'b0;
      for (int i = 0; i < NUM_QUEUES; i++) split_q[i] <= '0;
    end else begin
      rdc_q <= apply && wr_ctl && wr_strb[0] && wr_data[0];
      if (apply) begin
        bresp_q <= wr_ok ? OKAY : SLVERR;
        if (wr_qn) qnum_q <= qnum_sat;
        for (int i = 0; i < NUM_QUEUES; i++)
          if (wr_sr && (wr_idx[3:0] == 4'(i)))
            split_q[i] <= merge(split_q[i], wr_data, wr_strb);
      end
    end
  end

  assign r_idx = ARADDR[9:2];
  assign rd_dc = (r_idx[7:4] == 4'h1) && ({1'b0, r_idx[3:0]} < NQ5);
  assign rd_sr = (r_idx[7:4] == 4'h2) && ({1'b0, r_idx[3:0]} < NQ5);

  always_comb begin
    dc_sel = '0;
    sr_sel = '0;
    for (int i = 0; i < NUM_QUEUES; i++)
      if (r_idx[3:0] == 4'(i)) begin
        dc_sel = drop_count[DW*i +: DW];
        sr_sel = split_q[i];
      end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = SLVERR;
    unique case (1'b1)
      (r_idx == 8'h00): begin rd_data = qnum_q; rd_resp = OKAY; end
      (r_idx == 8'h01): rd_resp = OKAY;
      (r_idx == 8'h02): begin rd_data = NQW; rd_resp = OKAY; end
      rd_dc:            begin rd_data = dc_sel; rd_resp = OKAY; end
      rd_sr:            begin rd_data = sr_sel; rd_resp = OKAY; end
      default:          ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (ar_fire) begin
      rdata_q <= rd_data;
      rresp_q <= rd_resp;
    end
  end
endmodule

// File: tb/tb_oq_axi_regs.sv
// tb_oq_axi_regs: directed scoreboard bench for oq_axi_regs;
// responses are queued at issue and checked by a monitor.
module tb_oq_axi_regs;
  localparam int NQ = 5;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  logic clk = 1'b0;
  logic ARESETN;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA, queues_num;
  logic [3:0] WSTRB;
  logic AWVALID, AWREADY, WVALID, WREADY;
  logic [1:0] BRESP, RRESP;
  logic BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic reset_drop_counts;
  logic [32*NQ-1:0] split_ratio, drop_count, sr_exp;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int p0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [1:0]  be;
  logic [33:0] re;

  oq_axi_regs #(.NUM_QUEUES(NQ)) dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .queues_num(queues_num), .reset_drop_counts(reset_drop_counts),
    .split_ratio(split_ratio), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, no handshake seen", nm);
  endtask

  // Monitor: one pop per completed B or R handshake.
  always @(negedge clk) begin
    if (reset_drop_counts) pulses++;
    if (BVALID && BREADY) begin
      if (bq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL bresp_unexpected: got %b required none", BRESP);
      end else begin
        be = bq.pop_front();
        chk("bresp", BRESP, be);
      end
    end
    if (RVALID && RREADY) begin
      if (rq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rresp_unexpected: got %h required none", RDATA);
      end else begin
        re = rq.pop_front();
        chk("rdata", RDATA, re[31:0]);
        chk("rresp", RRESP, re[33:32]);
      end
    end
  end

  task automatic issue_w(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int awd, input int wd);
    bit awdone, wdone;
    int c;
    awdone = 0; wdone = 0; c = 0;
    AWADDR = a; WDATA = d; WSTRB = s;
    while (!(awdone && wdone) && c < 40) begin
      AWVALID = !awdone && (c >= awd);
      WVALID  = !wdone && (c >= wd);
      @(negedge clk);
      if (AWVALID && AWREADY) awdone = 1;
      if (WVALID && WREADY) wdone = 1;
      @(posedge clk); #1;
      c++;
    end
    AWVALID = 0; WVALID = 0;
    if (!(awdone && wdone)) tmo("aw_w_accept");
  endtask

  task automatic wait_b();
    bit hit;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (BVALID && BREADY) hit = 1;
      @(posedge clk); #1;
    end
    if (!hit) tmo("b_handshake");
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] e,
                       input int awd = 0, input int wd = 0);
    bq.push_back(e);
    issue_w(a, d, s, awd, wd);
    wait_b();
  endtask

  task automatic issue_ar(input logic [31:0] a);
    bit hit;
    hit = 0;
    ARADDR = a; ARVALID = 1;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (ARREADY) hit = 1;
      @(posedge clk); #1;
    end
    ARVALID = 0;
    if (!hit) tmo("ar_accept");
  endtask

  task automatic wait_r();
    bit hit;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (RVALID && RREADY) hit = 1;
      @(posedge clk); #1;
    end
    if (!hit) tmo("r_handshake");
  endtask

  task automatic read(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] e);
    rq.push_back({e, d});
    issue_ar(a);
    wait_r();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ARESETN = 0; AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0;
    WVALID = 0; BREADY = 1; ARADDR = 0; ARVALID = 0; RREADY = 1;
    drop_count = '0;
    sr_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_awready", AWREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_qnum", queues_num, 0);
    chk("rst_split", split_ratio, 0);
    ARESETN = 1;
    @(posedge clk); #1;
    chk("idle_awready", AWREADY, 1);

    read(32'h08, 32'd5, OK);
    read(32'h00, 32'd0, OK);

    write(32'h80, 32'hAABBCCDD, 4'b0101, OK);
    sr_exp[31:0] = 32'h00BB00DD;
    chk("split_strb", split_ratio, sr_exp);
    write(32'h84, 32'hAABBCCDD, 4'b0101, OK, 2, 0);
    sr_exp[63:32] = 32'h00BB00DD;
    chk("split_w_first", split_ratio, sr_exp);
    write(32'h88, 32'hAABBCCDD, 4'b1010, OK, 0, 3);
    sr_exp[95:64] = 32'hAA00CC00;
    chk("split_aw_first", split_ratio, sr_exp);

    write(32'h00, 32'd9, 4'hF, OK);
    chk("qnum_sat", queues_num, 5);
    read(32'h00, 32'd5, OK);
    write(32'h00, 32'd3, 4'hF, OK);
    chk("qnum_3", queues_num, 3);
    write(32'h00, 32'h100, 4'b0010, OK);
    chk("qnum_merge_sat", queues_num, 5);

    p0 = pulses;
    write(32'h04, 32'd1, 4'h1, OK);
    chk("rdc_pulse", pulses - p0, 1);
    p0 = pulses;
    write(32'h04, 32'd1, 4'h2, OK);
    chk("rdc_nostrb", pulses - p0, 0);
    p0 = pulses;
    write(32'h04, 32'd0, 4'hF, OK);
    chk("rdc_zero", pulses - p0, 0);
    read(32'h04, 32'd0, OK);

    drop_count[64 +: 32] = 32'h1234;
    RREADY = 0;
    rq.push_back({OK, 32'h1234});
    issue_ar(32'h48);
    drop_count[64 +: 32] = 32'h9999;
    repeat (3) @(posedge clk);
    #1;
    chk("rvalid_hold", RVALID, 1);
    RREADY = 1;
    wait_r();

    drop_count[31:0] = 32'hCAFE0000;
    read(32'h40, 32'hCAFE0000, OK);
    read(32'h54, 32'd0, SE);
    read(32'h94, 32'd0, SE);
    read(32'h90, 32'd0, OK);

    write(32'h40, 32'hFFFFFFFF, 4'hF, SE);
    write(32'h94, 32'hFFFFFFFF, 4'hF, SE);
    write(32'h08, 32'hFFFFFFFF, 4'hF, SE);
    chk("slverr_nochange", split_ratio, sr_exp);
    chk("slverr_qnum", queues_num, 5);
    read(32'h08, 32'd5, OK);

    fork
      write(32'h80, 32'h12345678, 4'hF, OK);
      read(32'h80, 32'h00BB00DD, OK);
    join
    sr_exp[31:0] = 32'h12345678;
    chk("split_after_rw", split_ratio, sr_exp);
    read(32'h483, 32'h12345678, OK);

    BREADY = 0;
    issue_w(32'h40, 32'h1, 4'hF, 0, 0);
    @(posedge clk); #1;
    chk("bvalid_pending", BVALID, 1);
    ARESETN = 0;
    @(posedge clk); #1;
    chk("rst2_bvalid", BVALID, 0);
    chk("rst2_bresp", BRESP, 0);
    chk("rst2_rdata", RDATA, 0);
    chk("rst2_qnum", queues_num, 0);
    chk("rst2_split", split_ratio, 0);
    chk("rst2_wready", WREADY, 0);
    chk("rst2_arready", ARREADY, 0);
    BREADY = 1;
    @(posedge clk); #1;
    ARESETN = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_stale_b", BVALID, 0);
    read(32'h80, 32'd0, OK);

    repeat (3) @(posedge clk);
    #1;
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/oq_axi_regs.md
# oq_axi_regs

Parametrised AXI4-Lite control/status register block for the BRAM output-queue subsystem. It replaces the fixed five-queue register bank with NUM_QUEUES channels, byte-strobed writes, AW/W acceptance in either order, saturating `queues_num`, and a self-clearing drop-counter reset pulse. It sits between the AXI4-Lite interconnect and the output-queue datapath. It drives configuration to the datapath and returns the datapath's live drop counters to software.

## Interface
- NUM_QUEUES, 5, number of queue channels; legal range 1..16
- DATA_WIDTH, 32, AXI4-Lite data width; only 32 is supported
- ADDR_WIDTH, 32, AXI4-Lite address width
- ACLK  in  1  single clock for all logic
- ARESETN  in  1  reset; synchronous, active-low
- AWADDR/AWVALID/AWREADY  in/in/out  ADDR_WIDTH/1/1  write address channel
- WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
- BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
- ARADDR/ARVALID/ARREADY  in/in/out  ADDR_WIDTH/1/1  read address channel
- RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel
- queues_num  out  32  number of active queues; always ≤ NUM_QUEUES
- reset_drop_counts  out  1  one-cycle pulse that clears the datapath drop counters
- split_ratio  out  32*NUM_QUEUES  split ratio for queue i, at bits [32i+31:32i]
- drop_count  in  32*NUM_QUEUES  live drop counter for queue i, at bits [32i+31:32i]

## Operation
- Register index is addr[9:2]; addr[1:0] and bits above 9 are ignored.
- Register map:
  - 0x00 QUEUES_NUM, RW. Before the write is applied, the value is built by merging the byte strobes with the current value. A merged value greater than NUM_QUEUES is stored as NUM_QUEUES.
  - 0x01 CONTROL, write-only. Writing bit0=1 with WSTRB[0]=1 produces one `reset_drop_counts` pulse. Reads return 0 with OKAY.
  - 0x02 NUM_QUEUES_CAP, RO. Returns the NUM_QUEUES parameter.
  - 0x10+i DROP_COUNT_i, RO.
  - 0x20+i SPLIT_RATIO_i, RW, byte-strobed.
- Any index i ≥ NUM_QUEUES in the 0x10/0x20 ranges is unmapped.
- Unmapped read: RRESP=SLVERR (2'b10), RDATA=0.
- Unmapped or RO write: BRESP=SLVERR, no state change.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, AW and W are captured independently, in either order or in the same cycle.
  - AWREADY = ~aw_held while in W_IDLE; WREADY = ~w_held while in W_IDLE.
  - When both are held, the write is applied on that clock edge. BRESP is registered, the held flags clear, and the FSM moves to W_RESP.
  - W_RESP: BVALID=1, AWREADY=WREADY=0. The FSM returns to W_IDLE on BREADY.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: ARREADY=1. On ARVALID, RDATA and RRESP are registered from the current register or input value, and the FSM moves to R_RESP.
  - R_RESP: RVALID=1, ARREADY=0. RDATA/RRESP are held stable. The FSM returns to R_IDLE on RREADY.
- The read and write paths are fully independent and may be busy at the same time.

## Timing
- Reset (ARESETN=0 at a clock edge):
  - Both FSMs go to IDLE; held flags clear.
  - `queues_num`, all `split_ratio` fields, `reset_drop_counts`, BVALID, RVALID, BRESP, RRESP and RDATA are all 0.
  - AWREADY, WREADY and ARREADY are forced to 0 while ARESETN=0.
- Reset mid-transaction abandons the transaction; no response is issued afterwards.
- Write latency: register outputs update on the edge where the second of AW/W is accepted. BVALID rises in the next cycle.
- `reset_drop_counts` is high for exactly the one cycle after that edge.
- Read latency: RVALID rises one cycle after the AR handshake.
- A read in the same cycle as a write that is being applied to the same register returns the old value.
- `drop_count` is sampled in the AR handshake cycle. Later changes do not alter a pending RDATA.
- BREADY or RREADY held high continuously gives one transaction per 2 cycles on each channel.

## Test plan
- Reset release, then read 0x02 with NUM_QUEUES=5 -> RDATA=5, OKAY. Read 0x00 -> 0.
- Write 0x20 (addr 0x80) with data 0xAABBCCDD and WSTRB=0b0101, over an initial 0 value -> split_ratio[31:0]=0x00BB00DD, BRESP=OKAY. Present W two cycles before AW -> same result, single BVALID.
- Write QUEUES_NUM=9 with NUM_QUEUES=5 -> queues_num=5. Write 3 -> 3.
- Write CONTROL=1 -> `reset_drop_counts` high exactly 1 cycle. Write CONTROL=0 -> no pulse.
- drop_count[2]=0x1234 and read 0x12; change the input to 0x9999 while RREADY=0 for 3 cycles -> RDATA stays 0x1234. Read 0x15 or 0x25 -> SLVERR, RDATA=0. Write 0x10 -> SLVERR, no change.
- Assert ARESETN=0 while BVALID=1 -> BVALID=0 next cycle, all outputs at reset values, no stale response after release.
